ascon_ps_serial: RTL and testbench

Serialised Ascon substitution layer (p_S) operating on the full 320-bit permutation state. Sits directly downstream of the constant-addition stage in the permutation round. It accepts a state word set over a valid/ready handshake and applies the 5-bit Ascon S-box to all 64 bit-columns, LANES columns per cycle, to trade latency for area. It then presents the substituted state to the linear-diffusion stage over a second valid/ready handshake.

---
 rtl/ascon_pkg.sv | 28 ++
 rtl/ascon_sbox5.sv | 11 +
 rtl/ascon_ps_serial.sv | 142 ++++++++++++++
 tb/tb_ascon_ps_serial.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation datapath: state widths,
// the 5-bit S-box table and the serial substitution FSM encoding.
package ascon_pkg;

  localparam int ASCON_STATE_W = 320;
  localparam int ASCON_WORD_W  = 64;

  typedef logic [ASCON_WORD_W-1:0] ascon_word_t;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_RUN  = 2'd1,
    PS_DONE = 2'd2
  } ps_state_e;

  // Index is {x0,x1,x2,x3,x4} of one bit-column, x0 as MSB.
  localparam logic [4:0] ASCON_SBOX [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  function automatic logic [4:0] ascon_sbox_lookup(input logic [4:0] x);
    return ASCON_SBOX[x];
  endfunction

endpackage

// File: rtl/ascon_sbox5.sv
// Combinational 5-bit Ascon S-box for a single bit-column.
module ascon_sbox5
  import ascon_pkg::*;
(
  input  logic [4:0] x,
  output logic [4:0] y
);

  assign y = ascon_sbox_lookup(x);

endmodule

// File: rtl/ascon_ps_serial.sv
// Serialised Ascon substitution layer: LANES bit-columns of the 320-bit state
// are substituted per cycle. Build with ASCON_PS_ZEROIZE_EN defined to clear the
// state register when the result is handed off.
//
// Handshake rule for both ports: a transfer happens on the rising edge where
// valid and ready are both 1; in_ready and out_valid are decoded from the FSM
// register only, so neither depends combinationally on the opposite signal.
module ascon_ps_serial
  import ascon_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ASCON_STATE_W-1:0] in_state,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ASCON_STATE_W-1:0] out_state,
  output logic                     busy,
  output ps_state_e                dbg_state
);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
      $error("ascon_ps_serial: LANES must be a power of two from 1 to 64");
    end
  endgenerate

  localparam int STEPS = ASCON_WORD_W / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  ps_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [ASCON_STATE_W-1:0] state_reg_q;
  logic [ASCON_STATE_W-1:0] state_sub;
  logic [5:0]               base;

  ascon_word_t w    [5];
  ascon_word_t nw   [5];
  logic [4:0]  sb_x [LANES];
  logic [4:0]  sb_y [LANES];

  // Word 0 (x0) sits in the top 64 bits of the packed state.
  for (genvar k = 0; k < 5; k++) begin : g_words
    assign w[k] = state_reg_q[ASCON_STATE_W-1-ASCON_WORD_W*k -: ASCON_WORD_W];
  end

  // First column handled this cycle; never exceeds 64-LANES.
  assign base = 6'(int'(cnt_q) * LANES);

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      sb_x[j] = {w[0][base + 6'(j)], w[1][base + 6'(j)], w[2][base + 6'(j)],
                 w[3][base + 6'(j)], w[4][base + 6'(j)]};
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    ascon_sbox5 u_sbox (
      .x (sb_x[j]),
      .y (sb_y[j])
    );
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      nw[k] = w[k];
    end
    for (int j = 0; j < LANES; j++) begin
      for (int k = 0; k < 5; k++) begin
        nw[k][base + 6'(j)] = sb_y[j][4-k];
      end
    end
    state_sub = {nw[0], nw[1], nw[2], nw[3], nw[4]};
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      PS_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = PS_RUN;
      end
      PS_RUN: begin
        busy = 1'b1;
        if (cnt_q == CNT_LAST) state_d = PS_DONE;
      end
      PS_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = PS_IDLE;
      end
      default: state_d = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      state_reg_q <= '0;
    end else begin
      case (state_q)
        PS_IDLE: begin
          if (in_valid) begin
            state_reg_q <= in_state;
            cnt_q       <= '0;
          end
        end
        PS_RUN: begin
          state_reg_q <= state_sub;
          // Counter parks on the last slice rather than wrapping.
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
        end
        PS_DONE: begin
`ifdef ASCON_PS_ZEROIZE_EN
          if (out_ready) state_reg_q <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign out_state = state_reg_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ascon_ps_serial.sv
// Directed bench for ascon_ps_serial: three instances (LANES 8, 1, 64) share
// clock and reset; results are checked against a column-wise S-box model.
module tb_ascon_ps_serial;
  import ascon_pkg::*;

  localparam int N = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid_v  [N];
  logic         in_ready_v  [N];
  logic [319:0] in_state_v  [N];
  logic         out_valid_v [N];
  logic         out_ready_v [N];
  logic [319:0] out_state_v [N];
  logic         busy_v      [N];
  ps_state_e    dbg_v       [N];

  int n_tests;
  int n_fail;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [319:0] ZERO_RES = {64'h0, 64'h0, ONES, 64'h0, 64'h0};
  localparam logic [319:0] ONES_RES = {ONES, 64'h0, ONES, ONES, ONES};

  localparam logic [7:0] REF_TBL [32] = '{
    8'h04, 8'h0B, 8'h1F, 8'h14, 8'h1A, 8'h15, 8'h09, 8'h02,
    8'h1B, 8'h05, 8'h08, 8'h12, 8'h1D, 8'h03, 8'h06, 8'h1C,
    8'h1E, 8'h13, 8'h07, 8'h0E, 8'h00, 8'h0D, 8'h11, 8'h18,
    8'h10, 8'h0C, 8'h01, 8'h19, 8'h16, 8'h0A, 8'h0F, 8'h17
  };

  for (genvar g = 0; g < N; g++) begin : g_dut
    ascon_ps_serial #(
      .LANES (g == 0 ? 8 : (g == 1 ? 1 : 64))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_state  (in_state_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_state (out_state_v[g]),
      .busy      (busy_v[g]),
      .dbg_state (dbg_v[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [319:0] ref_sub(input logic [319:0] s);
    logic [319:0] r;
    logic [4:0]   idx;
    logic [7:0]   v;
    r = s;
    for (int i = 0; i < 64; i++) begin
      idx = {s[256+i], s[192+i], s[128+i], s[64+i], s[i]};
      v = REF_TBL[idx];
      r[256+i] = v[4];
      r[192+i] = v[3];
      r[128+i] = v[2];
      r[64+i]  = v[1];
      r[i]     = v[0];
    end
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: present a state in IDLE, return cycles from accept edge to out_valid
  task automatic send(input int k, input logic [319:0] s, output int lat);
    @(negedge clk);
    in_state_v[k] = s;
    in_valid_v[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[k] = 1'b0;
    lat = 0;
    while (!out_valid_v[k] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take(input int k);
    @(negedge clk);
    out_ready_v[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[k] = 1'b0;
  endtask

  // scoreboard-style run: expected result queued, popped when DUT delivers
  task automatic run_one(input int k, input logic [319:0] s, input int exp_lat, input string tag);
    logic [319:0] exp_q[$];
    int lat;
    exp_q.push_back(ref_sub(s));
    send(k, s, lat);
    check({tag, "_lat"}, 320'(lat), 320'(exp_lat));
    check({tag, "_data"}, out_state_v[k], exp_q.pop_front());
    take(k);
  endtask

  initial begin
    int lat;
    logic [319:0] held;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_valid_v[k]  = 1'b0;
      in_state_v[k]  = '0;
      out_ready_v[k] = 1'b0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 320'(in_ready_v[0]), 320'(1));
    check("rst_out_valid", 320'(out_valid_v[0]), 320'(0));
    check("rst_busy", 320'(busy_v[0]), 320'(0));
    check("rst_out_state", out_state_v[0], '0);
    check("rst_fsm", 320'(dbg_v[0]), 320'(PS_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // zero state, LANES=8
    send(0, '0, lat);
    check("zero_lat", 320'(lat), 320'(8));
    check("zero_data", out_state_v[0], ZERO_RES);

    // backpressure: 5 cycles in DONE with in_valid pulses
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid_v[0] = c[0];
      in_state_v[0] = rand_state();
      @(posedge clk);
      #1;
      check("bp_out_valid", 320'(out_valid_v[0]), 320'(1));
      check("bp_in_ready", 320'(in_ready_v[0]), 320'(0));
      check("bp_out_state", out_state_v[0], ZERO_RES);
    end
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    take(0);
    check("post_hs_in_ready", 320'(in_ready_v[0]), 320'(1));
    check("post_hs_out_valid", 320'(out_valid_v[0]), 320'(0));
`ifdef ASCON_PS_ZEROIZE_EN
    check("post_hs_zeroize", out_state_v[0], '0);
`else
    check("post_hs_retain", out_state_v[0], ZERO_RES);
`endif

    // all-ones state
    send(0, {5{ONES}}, lat);
    check("ones_lat", 320'(lat), 320'(8));
    check("ones_data", out_state_v[0], ONES_RES);
    take(0);

    // reset mid-RUN
    @(negedge clk);
    in_state_v[0] = {5{ONES}};
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_busy", 320'(busy_v[0]), 320'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 320'(in_ready_v[0]), 320'(1));
    check("arst_out_valid", 320'(out_valid_v[0]), 320'(0));
    check("arst_busy", 320'(busy_v[0]), 320'(0));
    check("arst_out_state", out_state_v[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, '0, lat);
    check("arst_zero_lat", 320'(lat), 320'(8));
    check("arst_zero_data", out_state_v[0], ZERO_RES);
    take(0);

    // latency sweep
    run_one(1, '0, 64, "l1_zero");
    run_one(2, '0, 1, "l64_zero");
    run_one(1, {5{ONES}}, 64, "l1_ones");
    run_one(2, {5{ONES}}, 1, "l64_ones");

    // one-hot column patterns on the 8-lane build
    run_one(0, {64'h8000_0000_0000_0001, 64'h0, 64'h0, 64'h0, 64'h0}, 8, "x0_edges");
    run_one(0, {64'h0, 64'h0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF}, 8, "x4_pattern");

    // random states
    for (int i = 0; i < 200; i++) begin
      held = rand_state();
      run_one(0, held, 8, "rand_l8");
    end
    for (int i = 0; i < 10; i++) begin
      held = rand_state();
      run_one(1, held, 64, "rand_l1");
    end
    for (int i = 0; i < 20; i++) begin
      held = rand_state();
      run_one(2, held, 1, "rand_l64");
    end

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
